// File: rtl/cbus_arbiter_pkg.sv
// Shared CBus typedefs for the instruction/data arbiter.
//   cbus_req_t  : request from a core port (valid, is_write, size, addr, strobe, data, len)
//   cbus_resp_t : response toward a core port (ready, last, data)
//   arb_state_t : arbiter FSM encoding
//   port_t      : identifies the instruction (I) or data (D) port
package cbus_arbiter_pkg;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [3:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_t;

  // Winner when both ports request in the same IDLE cycle. Round-robin
  // hands the grant to whichever port did not finish most recently;
  // otherwise the data port always wins.
  function automatic port_t tie_winner(input logic round_robin, input port_t last_served);
    if (!round_robin)
      return PORT_D;
    return (last_served == PORT_I) ? PORT_D : PORT_I;
  endfunction

endpackage

// File: rtl/cbus_arbiter.sv
// Two-into-one CBus arbiter between the core's instruction and data ports
// and the CBus-to-AXI converter.
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   ireq/iresp : instruction-side request / response
//   dreq/dresp : data-side request / response
//   oreq/oresp : merged request / response toward the converter
// Only the FSM state and last_served are registered; all muxing is
// combinational from state, so a granted transaction sees the converter
// directly with no added latency after the one-cycle arbitration.
module cbus_arbiter
  import cbus_arbiter_pkg::*;
#(
  parameter int ROUND_ROBIN = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  ireq,
  output cbus_resp_t iresp,
  input  cbus_req_t  dreq,
  output cbus_resp_t dresp,
  output cbus_req_t  oreq,
  input  cbus_resp_t oresp
);

  arb_state_t state;
  port_t      last_served;

  logic rr_mode;
  logic done_beat;
  assign rr_mode   = (ROUND_ROBIN != 0);
  assign done_beat = oresp.ready & oresp.last;

  // Grant is held from arbitration until the last beat, regardless of the
  // requester's valid, so a burst is never split between ports.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last_served <= PORT_D;
    end else begin
      case (state)
        IDLE: begin
          if (ireq.valid && dreq.valid)
            state <= (tie_winner(rr_mode, last_served) == PORT_I) ? BUSY_I : BUSY_D;
          else if (ireq.valid)
            state <= BUSY_I;
          else if (dreq.valid)
            state <= BUSY_D;
        end
        BUSY_I: begin
          if (done_beat) begin
            state       <= IDLE;
            last_served <= PORT_I;
          end
        end
        BUSY_D: begin
          if (done_beat) begin
            state       <= IDLE;
            last_served <= PORT_D;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // In IDLE (including while reset holds state there) everything is zero.
  always_comb begin
    oreq  = '0;
    iresp = '0;
    dresp = '0;
    case (state)
      BUSY_I: begin
        oreq  = ireq;
        iresp = oresp;
      end
      BUSY_D: begin
        oreq  = dreq;
        dresp = oresp;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cbus_arbiter.sv
module tb_cbus_arbiter;
  import cbus_arbiter_pkg::*;

  typedef struct packed {
    logic             port;      // 0 = I, 1 = D
    logic             is_write;
    logic [31:0]      addr;
    logic [3:0]       strobe;
    logic [31:0]      wdata;
    logic [3:0]       len;
    logic [15:0][31:0] beats;
  } txn_t;

  typedef struct packed {
    logic        port;
    logic        last;
    logic [31:0] data;
  } beat_t;

  logic       clk;
  logic       reset;
  logic       sel_rr;
  cbus_req_t  ireq, dreq;
  cbus_resp_t oresp;
  cbus_resp_t oresp_rr, oresp_fp;
  cbus_req_t  oreq, oreq_rr, oreq_fp;
  cbus_resp_t iresp, iresp_rr, iresp_fp;
  cbus_resp_t dresp, dresp_rr, dresp_fp;

  int n_tests = 0;
  int n_fail  = 0;

  txn_t  rq_i[$];
  txn_t  rq_d[$];
  txn_t  exp_q[$];
  beat_t sb_q[$];
  txn_t  cur;
  bit    conv_in_txn;
  bit    conv_ending;
  int    beat;
  int    uid = 0;

  assign oresp_rr = sel_rr ? oresp : '0;
  assign oresp_fp = sel_rr ? '0 : oresp;
  assign oreq  = sel_rr ? oreq_rr  : oreq_fp;
  assign iresp = sel_rr ? iresp_rr : iresp_fp;
  assign dresp = sel_rr ? dresp_rr : dresp_fp;

  cbus_arbiter #(.ROUND_ROBIN(1)) u_rr (
    .clk(clk), .reset(reset), .ireq(ireq), .iresp(iresp_rr),
    .dreq(dreq), .dresp(dresp_rr), .oreq(oreq_rr), .oresp(oresp_rr)
  );

  cbus_arbiter #(.ROUND_ROBIN(0)) u_fp (
    .clk(clk), .reset(reset), .ireq(ireq), .iresp(iresp_fp),
    .dreq(dreq), .dresp(dresp_fp), .oreq(oreq_fp), .oresp(oresp_fp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic cbus_req_t to_req(input txn_t t);
    cbus_req_t r;
    r.valid    = 1'b1;
    r.is_write = t.is_write;
    r.size     = 3'd2;
    r.addr     = t.addr;
    r.strobe   = t.strobe;
    r.data     = t.wdata;
    r.len      = t.len;
    return r;
  endfunction

  function automatic txn_t gen_txn(input logic p);
    txn_t t;
    t.port     = p;
    t.is_write = 1'($urandom_range(0, 1));
    t.addr     = (p ? 32'h8000_0000 : 32'hBFC0_0000) + 32'(uid * 4);
    t.strobe   = 4'($urandom_range(0, 15));
    t.wdata    = $urandom;
    t.len      = 4'($urandom_range(0, 3));
    for (int b = 0; b < 16; b++) t.beats[b] = $urandom;
    uid++;
    return t;
  endfunction

  // Requester: presents the head of its queue continuously and moves to
  // the next transaction after seeing its own last beat.
  task automatic req_proc(input bit p);
    bit done;
    done = 1'b0;
    forever begin
      @(negedge clk); #1;
      if (!reset && (p ? (dresp.ready && dresp.last) : (iresp.ready && iresp.last))) done = 1'b1;
      @(posedge clk); #1;
      if (reset) begin
        done = 1'b0;
        if (p) begin rq_d.delete(); dreq = '0; end
        else   begin rq_i.delete(); ireq = '0; end
      end else begin
        if (p) begin
          if (done && rq_d.size() != 0) void'(rq_d.pop_front());
          dreq = (rq_d.size() != 0) ? to_req(rq_d[0]) : '0;
        end else begin
          if (done && rq_i.size() != 0) void'(rq_i.pop_front());
          ireq = (rq_i.size() != 0) ? to_req(rq_i[0]) : '0;
        end
        done = 1'b0;
      end
    end
  endtask

  initial req_proc(1'b0);
  initial req_proc(1'b1);

  // Converter model: on a new grant takes the next transaction in the
  // reference order, returns beats with random ready gaps, and records
  // each beat it returns in the scoreboard.
  initial begin
    oresp = '0;
    conv_in_txn = 1'b0;
    conv_ending = 1'b0;
    beat = 0;
    forever begin
      @(negedge clk);
      oresp = '0;
      if (reset) begin
        conv_in_txn = 1'b0;
        conv_ending = 1'b0;
      end else begin
        if (conv_ending) begin conv_in_txn = 1'b0; conv_ending = 1'b0; end
        if (!conv_in_txn && oreq.valid && exp_q.size() != 0) begin
          cur = exp_q.pop_front();
          conv_in_txn = 1'b1;
          beat = 0;
        end
        if (conv_in_txn && $urandom_range(0, 2) != 0) begin
          oresp.ready = 1'b1;
          oresp.data  = cur.beats[beat];
          oresp.last  = (beat == int'(cur.len));
          sb_q.push_back('{port: cur.port, last: oresp.last, data: oresp.data});
          if (oresp.last) conv_ending = 1'b1;
          beat++;
        end
      end
    end
  end

  // Monitor
  initial begin
    bit prev_ov, prev_arb, prev2_arb, prev_last, ov, any_req;
    beat_t e;
    cbus_resp_t exp_i, exp_d;
    prev_ov = 0; prev_arb = 0; prev2_arb = 0; prev_last = 0;
    forever begin
      @(negedge clk); #2;
      if (reset) begin
        prev_ov = 0; prev_arb = 0; prev2_arb = 0; prev_last = 0;
      end else begin
        ov = oreq.valid;
        any_req = ireq.valid | dreq.valid;
        if (ov) begin
          if (conv_in_txn) chk(oreq == to_req(cur), "oreq_match", oreq, to_req(cur));
          else             chk(1'b0, "unexpected_grant", oreq, '0);
          if (!prev_ov) chk(prev_arb && !prev2_arb, "arb_latency", {prev2_arb, prev_arb}, 2'b01);
        end else begin
          chk(iresp == '0 && dresp == '0, "idle_resp_zero", {iresp, dresp}, '0);
        end
        if (prev_last) chk(!ov, "idle_gap", ov, 1'b0);
        if (iresp.ready || dresp.ready) begin
          if (sb_q.size() == 0) begin
            chk(1'b0, "unexpected_beat", {iresp, dresp}, '0);
          end else begin
            e = sb_q.pop_front();
            exp_i = '0; exp_d = '0;
            if (e.port) begin exp_d.ready = 1'b1; exp_d.last = e.last; exp_d.data = e.data; end
            else        begin exp_i.ready = 1'b1; exp_i.last = e.last; exp_i.data = e.data; end
            chk(iresp == exp_i && dresp == exp_d, "resp_beat", {iresp, dresp}, {exp_i, exp_d});
          end
        end else if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          chk(1'b0, "missing_beat", {iresp, dresp}, {1'b1, e.last, e.data});
        end
        prev2_arb = prev_arb;
        prev_arb  = any_req && !ov;
        prev_ov   = ov;
        prev_last = (iresp.ready && iresp.last) || (dresp.ready && dresp.last);
      end
    end
  end

  task automatic reset_pulse(input bit rr);
    @(negedge clk); #3;
    reset = 1'b1;
    #1;
    sel_rr = rr;
    exp_q.delete(); sb_q.delete(); rq_i.delete(); rq_d.delete();
    #1;
    chk(oreq == '0 && iresp == '0 && dresp == '0, "reset_outputs", {oreq, iresp, dresp}, '0);
    @(negedge clk); #3;
    reset = 1'b0;
  endtask

  // Reference order: with both ports always pending, round-robin alternates
  // starting from I (whichever did not finish last); fixed priority drains D
  // first. Once one side is empty the other is served in order.
  task automatic run_load(input int n_i, input int n_d);
    txn_t ti[$], td[$];
    int i, d;
    bit turn, pick, finished;
    for (int k = 0; k < n_i; k++) ti.push_back(gen_txn(1'b0));
    for (int k = 0; k < n_d; k++) td.push_back(gen_txn(1'b1));
    i = 0; d = 0; turn = 1'b0;
    while (i < n_i || d < n_d) begin
      if (i < n_i && d < n_d) pick = sel_rr ? turn : 1'b1;
      else                    pick = (i < n_i) ? 1'b0 : 1'b1;
      if (pick) begin exp_q.push_back(td[d]); d++; end
      else      begin exp_q.push_back(ti[i]); i++; end
      turn = ~pick;
    end
    foreach (ti[k]) rq_i.push_back(ti[k]);
    foreach (td[k]) rq_d.push_back(td[k]);
    finished = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk); #3;
      if (rq_i.size() == 0 && rq_d.size() == 0 && !conv_in_txn && exp_q.size() == 0) begin
        finished = 1'b1;
        break;
      end
    end
    chk(finished, "scenario_done", finished, 1'b1);
    repeat (2) @(negedge clk);
    #3;
    chk(exp_q.size() == 0 && sb_q.size() == 0, "queues_drained", exp_q.size() + sb_q.size(), 0);
  endtask

  task automatic scenario(input bit rr, input int n_i, input int n_d);
    reset_pulse(rr);
    run_load(n_i, n_d);
  endtask

  // Reset in the middle of an I burst must zero outputs at once, and the
  // first tie afterwards must go to I even though I finished last before.
  task automatic mid_burst_reset();
    txn_t t;
    bit hit;
    reset_pulse(1'b1);
    run_load(1, 0);
    t = gen_txn(1'b0);
    t.len = 4'd7;
    exp_q.push_back(t);
    rq_i.push_back(t);
    hit = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk); #3;
      if (iresp.ready && !iresp.last) begin hit = 1'b1; break; end
    end
    chk(hit, "mid_burst_reached", hit, 1'b1);
    reset = 1'b1;
    #1;
    chk(oreq.valid == 1'b0, "reset_oreq_valid", oreq.valid, 1'b0);
    chk(iresp == '0 && dresp == '0, "reset_resp_zero", {iresp, dresp}, '0);
    exp_q.delete(); sb_q.delete(); rq_i.delete(); rq_d.delete();
    @(negedge clk); #3;
    reset = 1'b0;
    run_load(1, 1);
  endtask

  initial begin
    reset  = 1'b1;
    sel_rr = 1'b1;
    ireq   = '0;
    dreq   = '0;
    repeat (2) @(negedge clk);
    scenario(1'b1, 1, 0);
    scenario(1'b1, 0, 1);
    scenario(1'b1, 4, 4);
    scenario(1'b0, 4, 4);
    scenario(1'b0, 3, 1);
    scenario(1'b1, 2, 5);
    for (int r = 0; r < 8; r++)
      scenario(1'($urandom_range(0, 1)), $urandom_range(0, 5), $urandom_range(0, 5));
    mid_burst_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cbus_arbiter.md
CBUS_ARBITER -- requirements
Module: cbus_arbiter

Interface
REQ-001 SHALL take parameter ROUND_ROBIN, default 1, meaning alternate grants on contention; 0 means fixed data-port priority.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port ireq  input  cbus_req_t  instruction-side request (valid, is_write, size, addr, strobe, data, len).
REQ-005 SHALL have port iresp  output  cbus_resp_t  instruction-side response (ready, last, data).
REQ-006 SHALL have port dreq  input  cbus_req_t  data-side request.
REQ-007 SHALL have port dresp  output  cbus_resp_t  data-side response.
REQ-008 SHALL have port oreq  output  cbus_req_t  merged request to the CBus-to-AXI converter.
REQ-009 SHALL have port oresp  input  cbus_resp_t  response from the converter.

Function
REQ-010 SHALL implement FSM states IDLE, BUSY_I, BUSY_D, held in a registered state variable.
REQ-011 In IDLE, oreq SHALL be all-zero and iresp and dresp SHALL be all-zero.
REQ-012 IDLE->BUSY_I when only ireq.valid=1; IDLE->BUSY_D when only dreq.valid=1; no change when neither is valid.
REQ-013 With both valid in IDLE and ROUND_ROBIN=1, the grant SHALL go to the port not recorded in last_served; with ROUND_ROBIN=0 it SHALL go to D.
REQ-014 The arbitration decision SHALL take exactly one cycle: the request is observed valid in cycle N, and oreq.valid is first asserted in cycle N+1.
REQ-015 In BUSY_x, oreq SHALL equal the granted port's request combinationally.
REQ-016 In BUSY_x, the granted response SHALL equal oresp, and the other port's response SHALL be all-zero.
REQ-017 BUSY_x->IDLE SHALL occur on the edge where oresp.ready=1 and oresp.last=1; last_served SHALL be updated to x on that same edge.
REQ-018 Intermediate burst beats (ready=1, last=0) SHALL NOT release the grant.
REQ-019 Once granted, the grant SHALL be held to the last beat even if the granted requester deasserts valid (protocol violation); oreq.valid then follows the requester.
REQ-020 A request arriving on the other port during BUSY_x SHALL wait; it SHALL be arbitrated in the IDLE cycle after release.
REQ-021 Back-to-back transactions SHALL therefore have one idle cycle between the last beat and the next oreq.valid.
REQ-022 Single-beat transactions (len=0) SHALL complete on the first ready with last=1, with no special casing.

Reset
REQ-023 Asserting reset SHALL force state=IDLE and last_served=D immediately, independent of clk.
REQ-024 While reset is asserted, oreq, iresp and dresp SHALL be all-zero.
REQ-025 Reset during BUSY_x SHALL abandon the transaction; the converter is reset in the same domain.
REQ-026 After reset deassertion, the first tie SHALL be granted to I when ROUND_ROBIN=1.

Structure
REQ-027 cbus_req_t, cbus_resp_t and the state enum SHALL live in the shared common package, alongside the existing bus typedefs.
REQ-028 No sub-module SHALL be used.
REQ-029 Request and response muxing SHALL be combinational from state; only state and last_served are flops.
REQ-030 The block SHALL sit between the core's instruction and data cbus ports and the CBus-to-AXI converter.

Verification
REQ-031 Stimulus: ireq.valid=1 only, addr=0xBFC00000, len=0; oresp ready=1, last=1, data=0x3C080001 in cycle 2. Required: oreq.valid=1 in cycle 1; iresp.data=0x3C080001 with ready=1; IDLE in cycle 3.
REQ-032 Stimulus: ireq and dreq both valid from reset, ROUND_ROBIN=1. Required: I is served first, then D; order I,D,I,D over 4 transactions.
REQ-033 Stimulus: same as REQ-032 with ROUND_ROBIN=0. Required: D wins every tie; I is served only when dreq.valid=0.
REQ-034 Stimulus: D write burst len=3 with oresp.ready=1 on 4 beats and last on beat 4, while ireq is valid throughout. Required: iresp stays zero for all 4 beats; I is granted 2 cycles after beat 4.
REQ-035 Stimulus: reset pulsed mid-burst in BUSY_I, between clock edges. Required: oreq.valid=0 and iresp=0 immediately; state=IDLE.
REQ-036 Stimulus: oresp.ready toggles 1,0,1 with last=0,0,1. Required: the grant is held until the third beat, then released.
